// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: report encoding, scheduler states, LFSR taps.
package whack_pkg;

  // Result codes carried on hit_miss; the game controller decodes the same values.
  localparam logic [1:0] HM_NONE = 2'b00;
  localparam logic [1:0] HM_HIT  = 2'b01;
  localparam logic [1:0] HM_MISS = 2'b10;

  // Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Round sequencing states of the mole scheduler.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GAP    = 3'd1,
    ACTIVE = 3'd2,
    REPORT = 3'd3,
    HOLD   = 3'd4
  } sched_state_e;

  // One right-shift step of the Galois LFSR.
  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_MASK;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mole_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick mole holes.
module lfsr16
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: shift right, folding the taps back in when a one falls out.
  always_comb begin
    lfsr_d = lfsrStep(lfsr_q);
  end

  // Advance on every clock regardless of what the rest of the game is doing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Mole round sequencer: dark gap, lit window, hit/miss judgement, report held until the controller leaves Game.
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int          NUM_HOLES   = 4,
  parameter int          CNT_W       = 26,
  parameter int          GAP_CYCLES  = 12_500_000,
  parameter int          WINDOW_INIT = 50_000_000,
  parameter int          WINDOW_MIN  = 10_000_000,
  parameter int          WINDOW_STEP = 2_500_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic [1:0]           hit_miss,
  output logic [7:0]           hit_count
);

  // NUM_HOLES is restricted to 2, 4 or 8 so the hole index is a plain bit slice of the LFSR.
  localparam int HOLE_W = $clog2(NUM_HOLES);

  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] WIN_INIT_V = CNT_W'(WINDOW_INIT);
  localparam logic [CNT_W-1:0] WIN_MIN_V  = CNT_W'(WINDOW_MIN);
  localparam logic [CNT_W-1:0] WIN_STEP_V = CNT_W'(WINDOW_STEP);
  // One bit wider so the "can we still shrink" test never wraps.
  localparam logic [CNT_W:0]   SHRINK_LIMIT = (CNT_W+1)'(WINDOW_MIN + WINDOW_STEP);

  sched_state_e state_q, state_d;
  logic [CNT_W-1:0]     gapCnt_q, gapCnt_d;
  logic [CNT_W-1:0]     winCnt_q, winCnt_d;
  logic [CNT_W-1:0]     windowLen_q, windowLen_d;
  logic [NUM_HOLES-1:0] prevButtons_q;
  logic [HOLE_W-1:0]    prevIdx_q, prevIdx_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [1:0]           hitMiss_q, hitMiss_d;
  logic [7:0]           hitCount_q, hitCount_d;

  logic [15:0]          lfsrState;
  logic [HOLE_W-1:0]    rawIdx;
  logic [HOLE_W-1:0]    pickIdx;
  logic [NUM_HOLES-1:0] rise;
  logic                 targetRise;
  logic                 otherRise;
  logic                 unusedLfsrBits;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .state_o(lfsrState)
  );

  // Only the low bits pick a hole; the rest of the LFSR state just keeps the sequence long.
  assign unusedLfsrBits = ^lfsrState[15:HOLE_W];

  // Candidate hole, bumped to the neighbour so the same hole never lights twice in a row.
  always_comb begin
    rawIdx  = lfsrState[HOLE_W-1:0];
    pickIdx = rawIdx;
    if (rawIdx == prevIdx_q) begin
      pickIdx = rawIdx + HOLE_W'(1);
    end
  end

  // Press detection: only fresh rising edges count, split into the lit hole and every other hole.
  always_comb begin
    rise       = buttons & ~prevButtons_q;
    targetRise = |(rise & mole_q);
    otherRise  = |(rise & ~mole_q);
  end

  // Round sequencing, judgement, score and difficulty updates.
  always_comb begin
    state_d     = state_q;
    gapCnt_d    = gapCnt_q;
    winCnt_d    = winCnt_q;
    windowLen_d = windowLen_q;
    prevIdx_d   = prevIdx_q;
    mole_d      = mole_q;
    hitMiss_d   = hitMiss_q;
    hitCount_d  = hitCount_q;

    if (start) begin
      state_d     = IDLE;
      hitCount_d  = 8'd0;
      windowLen_d = WIN_INIT_V;
      mole_d      = '0;
      hitMiss_d   = HM_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          mole_d    = '0;
          hitMiss_d = HM_NONE;
          if (enable) begin
            state_d  = GAP;
            gapCnt_d = GAP_LOAD;
          end
        end

        GAP: begin
          mole_d = '0;
          if (!enable) begin
            state_d = IDLE;
          end else if (gapCnt_q <= CNT_W'(1)) begin
            state_d   = ACTIVE;
            prevIdx_d = pickIdx;
            mole_d    = NUM_HOLES'(1) << pickIdx;
            winCnt_d  = windowLen_q;
          end else begin
            gapCnt_d = gapCnt_q - CNT_W'(1);
          end
        end

        ACTIVE: begin
          if (!enable) begin
            state_d = IDLE;
            mole_d  = '0;
          end else if (otherRise) begin
            state_d   = REPORT;
            mole_d    = '0;
            hitMiss_d = HM_MISS;
          end else if (targetRise) begin
            state_d   = REPORT;
            mole_d    = '0;
            hitMiss_d = HM_HIT;
            if (hitCount_q != 8'hFF) begin
              hitCount_d = hitCount_q + 8'd1;
            end
            if ({1'b0, windowLen_q} >= SHRINK_LIMIT) begin
              windowLen_d = windowLen_q - WIN_STEP_V;
            end else begin
              windowLen_d = WIN_MIN_V;
            end
          end else if (winCnt_q <= CNT_W'(1)) begin
            state_d   = REPORT;
            mole_d    = '0;
            hitMiss_d = HM_MISS;
          end else begin
            winCnt_d = winCnt_q - CNT_W'(1);
          end
        end

        REPORT: begin
          if (!enable) begin
            state_d   = HOLD;
            hitMiss_d = HM_NONE;
          end
        end

        HOLD: begin
          if (enable) begin
            state_d  = GAP;
            gapCnt_d = GAP_LOAD;
          end
        end

        default: begin
          state_d   = IDLE;
          mole_d    = '0;
          hitMiss_d = HM_NONE;
        end
      endcase
    end
  end

  // State register; buttons held through reset look "already pressed" so they cannot fake a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      gapCnt_q      <= '0;
      winCnt_q      <= '0;
      windowLen_q   <= WIN_INIT_V;
      prevButtons_q <= '1;
      prevIdx_q     <= '0;
      mole_q        <= '0;
      hitMiss_q     <= HM_NONE;
      hitCount_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      gapCnt_q      <= gapCnt_d;
      winCnt_q      <= winCnt_d;
      windowLen_q   <= windowLen_d;
      prevButtons_q <= buttons;
      prevIdx_q     <= prevIdx_d;
      mole_q        <= mole_d;
      hitMiss_q     <= hitMiss_d;
      hitCount_q    <= hitCount_d;
    end
  end

  assign mole_onehot = mole_q;
  assign hit_miss    = hitMiss_q;
  assign hit_count   = hitCount_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with a small-parameter build and an independent LFSR/hole model.
module tb_mole_scheduler;
  import whack_pkg::*;

  localparam int NH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          enable;
  logic [NH-1:0] buttons;
  logic [NH-1:0] moleOnehot;
  logic [1:0]    hitMiss;
  logic [7:0]    hitCount;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] modelLfsr;
  logic [15:0] modelPrev;
  int          benchPrev;
  logic [3:0]  lastMole;

  typedef struct {
    int         kind;
    int         delay;
    logic [1:0] expHm;
    int         expLat;
    int         expCount;
    int         expWlen;
  } roundVec_t;

  roundVec_t vecs[10];

  mole_scheduler #(
    .NUM_HOLES  (NH),
    .CNT_W      (26),
    .GAP_CYCLES (4),
    .WINDOW_INIT(10),
    .WINDOW_MIN (4),
    .WINDOW_STEP(3),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .enable     (enable),
    .buttons    (buttons),
    .mole_onehot(moleOnehot),
    .hit_miss   (hitMiss),
    .hit_count  (hitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR step written straight from the polynomial.
  function automatic logic [15:0] modelStep(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0] == 1'b1) n = n ^ 16'hB400;
    return n;
  endfunction

  // Bench copy of the LFSR; modelPrev is the value the DUT saw at the latest edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      modelLfsr <= 16'hACE1;
      modelPrev <= 16'hACE1;
    end else begin
      modelPrev <= modelLfsr;
      modelLfsr <= modelStep(modelLfsr);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic waitLight(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (moleOnehot == '0 && edges < 40);
  endtask

  task automatic checkHole(input string tag);
    int p;
    logic [3:0] expMole;
    p = int'(modelPrev[1:0]);
    if (p == benchPrev) p = (p + 1) % NH;
    benchPrev = p;
    expMole = 4'b0001 << p;
    checkOutput({tag, "/hole"}, 32'(moleOnehot), 32'(expMole));
    checkOutput({tag, "/newHole"}, 32'(moleOnehot != lastMole), 32'd1);
    lastMole = expMole;
  endtask

  // One round: kind 0 none, 1 target, 2 other hole, 3 target+other together.
  task automatic applyStimulus(input int kind, input int delay, input logic [1:0] expHm,
                               input int expLat, input int expCount, input int expWlen,
                               input bit dropAfter, input string tag);
    int edges;
    int lat;
    bit pressed;
    logic [3:0] tgt, other, mask;
    enable = 1'b1;
    waitLight(edges);
    checkOutput({tag, "/lightEdge"}, 32'(edges), 32'd5);
    checkHole(tag);
    tgt   = 4'b0001 << benchPrev;
    other = {tgt[2:0], tgt[3]};
    case (kind)
      1:       mask = tgt;
      2:       mask = other;
      3:       mask = tgt | other;
      default: mask = 4'b0000;
    endcase
    lat = 0;
    pressed = 1'b0;
    while (hitMiss == HM_NONE && lat < 40) begin
      if (kind != 0 && !pressed && lat == delay) begin
        buttons = mask;
        pressed = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "/hitMiss"}, 32'(hitMiss), 32'(expHm));
    checkOutput({tag, "/moleOff"}, 32'(moleOnehot), 32'd0);
    checkOutput({tag, "/hitCount"}, 32'(hitCount), 32'(expCount));
    checkOutput({tag, "/windowLen"}, 32'(dut.windowLen_q), 32'(expWlen));
    buttons = '0;
    if (dropAfter) begin
      enable = 1'b0;
      @(posedge clk); #1;
      checkOutput({tag, "/hmCleared"}, 32'(hitMiss), 32'(HM_NONE));
      checkOutput({tag, "/inHold"}, 32'(dut.state_q), 32'(HOLD));
    end
  endtask

  initial begin
    int e;
    vecs[0] = '{1, 3, HM_HIT,  4, 1, 7};
    vecs[1] = '{0, 0, HM_MISS, 7, 1, 7};
    vecs[2] = '{3, 2, HM_MISS, 3, 1, 7};
    vecs[3] = '{2, 0, HM_MISS, 1, 1, 7};
    vecs[4] = '{1, 0, HM_HIT,  1, 2, 4};
    vecs[5] = '{1, 1, HM_HIT,  2, 3, 4};
    vecs[6] = '{1, 2, HM_HIT,  3, 4, 4};
    vecs[7] = '{1, 0, HM_HIT,  1, 5, 4};
    vecs[8] = '{0, 0, HM_MISS, 4, 5, 4};
    vecs[9] = '{1, 3, HM_HIT,  4, 6, 4};

    benchPrev = 0;
    lastMole  = 4'b0001;
    reset   = 1'b1;
    start   = 1'b0;
    enable  = 1'b0;
    buttons = '0;
    #12;
    checkOutput("reset/mole", 32'(moleOnehot), 32'd0);
    checkOutput("reset/hitMiss", 32'(hitMiss), 32'd0);
    checkOutput("reset/hitCount", 32'(hitCount), 32'd0);
    checkOutput("reset/state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("reset/windowLen", 32'(dut.windowLen_q), 32'd10);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].delay, vecs[i].expHm, vecs[i].expLat,
                    vecs[i].expCount, vecs[i].expWlen, 1'b1, $sformatf("vec%0d", i));
    end

    // start in REPORT clears score and difficulty
    applyStimulus(1, 0, HM_HIT, 1, 7, 4, 1'b0, "preStart");
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    enable = 1'b0;
    checkOutput("start/hitMiss", 32'(hitMiss), 32'd0);
    checkOutput("start/hitCount", 32'(hitCount), 32'd0);
    checkOutput("start/windowLen", 32'(dut.windowLen_q), 32'd10);
    checkOutput("start/state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("start/mole", 32'(moleOnehot), 32'd0);
    @(posedge clk); #1;

    // hit counter saturation
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(1, 0, HM_HIT, 1, (k > 255) ? 255 : k, (k == 1) ? 7 : 4, 1'b1, "sat");
    end

    // enable dropped while the mole is lit
    enable = 1'b1;
    waitLight(e);
    checkOutput("dropActive/lightEdge", 32'(e), 32'd5);
    checkHole("dropActive");
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("dropActive/mole", 32'(moleOnehot), 32'd0);
    checkOutput("dropActive/hitMiss", 32'(hitMiss), 32'd0);
    checkOutput("dropActive/state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    checkOutput("dropActive/hitMissLater", 32'(hitMiss), 32'd0);

    // asynchronous reset in GAP
    enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("gapReset/inGap", 32'(dut.state_q), 32'(GAP));
    checkOutput("gapReset/countBefore", 32'(hitCount), 32'd255);
    #3 reset = 1'b1;
    #1;
    checkOutput("gapReset/hitCount", 32'(hitCount), 32'd0);
    checkOutput("gapReset/mole", 32'(moleOnehot), 32'd0);
    checkOutput("gapReset/hitMiss", 32'(hitMiss), 32'd0);
    benchPrev = 0;
    lastMole  = 4'b0001;
    buttons   = '1;
    #2 reset = 1'b0;

    // buttons held through reset never register as a press
    applyStimulus(0, 0, HM_MISS, 10, 0, 10, 1'b1, "heldBtn");
    applyStimulus(1, 1, HM_HIT, 2, 1, 7, 1'b1, "postReset");

    // asynchronous reset while the mole is lit
    enable = 1'b1;
    waitLight(e);
    checkOutput("activeReset/lightEdge", 32'(e), 32'd5);
    checkHole("activeReset");
    @(posedge clk); #1;
    #3 reset = 1'b1;
    #1;
    checkOutput("activeReset/mole", 32'(moleOnehot), 32'd0);
    checkOutput("activeReset/hitCount", 32'(hitCount), 32'd0);
    checkOutput("activeReset/hitMiss", 32'(hitMiss), 32'd0);
    checkOutput("activeReset/state", 32'(dut.state_q), 32'(IDLE));
    enable = 1'b0;
    #2 reset = 1'b0;
    #20;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
